// File: rtl/best_1ofn_pipe.sv
// Best-of-NPAT pattern sorter: candidates are qualified against a threshold, then reduced
// by a compare-by-twos tree whose per-stage registers are chosen with PIPE_MASK.
module best_1ofn_pipe #(
  parameter int unsigned NPAT      = 32,
  parameter int unsigned MXPATB    = 7,
  parameter int unsigned MXPATC    = 8,
  parameter int unsigned SORT_HI   = 6,
  parameter int unsigned SORT_LO   = 1,
  parameter int unsigned MXKEYB    = $clog2(NPAT),
  parameter logic [31:0] PIPE_MASK = 32'b01000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       vld_in,
  input  logic [SORT_HI-SORT_LO:0]   thresh,
  input  logic [NPAT*MXPATB-1:0]     pat_in,
  input  logic [NPAT*MXPATC-1:0]     carry_in,
  output logic [MXPATB-1:0]          best_pat,
  output logic [MXKEYB-1:0]          best_key,
  output logic [MXPATC-1:0]          best_carry,
  output logic                       best_vld,
  output logic [MXKEYB:0]            nqual
);

  localparam int unsigned NST = $clog2(NPAT);
  localparam int unsigned FW  = SORT_HI - SORT_LO + 1;
  localparam int unsigned NQW = MXKEYB + 1;

  typedef struct packed {
    logic [MXPATB-1:0] pat;
    logic [MXPATC-1:0] carry;
    logic [FW-1:0]     s;
    logic              q;
    logic [MXKEYB-1:0] key;
  } elem_t;

  elem_t           in_e [NPAT];
  logic [NPAT-1:0] in_q;
  logic [NQW-1:0]  in_nq;

  always_comb begin
    in_nq = '0;
    for (int k = 0; k < NPAT; k++) begin
      in_q[k]        = vld_in && (pat_in[k*MXPATB+SORT_LO +: FW] >= thresh);
      in_e[k].pat    = pat_in[k*MXPATB +: MXPATB];
      in_e[k].carry  = carry_in[k*MXPATC +: MXPATC];
      in_e[k].s      = in_q[k] ? pat_in[k*MXPATB+SORT_LO +: FW] : '0;
      in_e[k].q      = in_q[k];
      in_e[k].key    = '0;
      in_nq          = in_nq + NQW'(in_q[k]);
    end
  end

  for (genvar s = 0; s < NST; s++) begin : g_st
    localparam int unsigned NO = NPAT >> (s + 1);

    elem_t          i_e [2*NO];
    logic [NQW-1:0] i_nq;
    logic           i_vld;
    elem_t          c_e [NO];
    elem_t          o_e [NO];
    logic [NQW-1:0] o_nq;
    logic           o_vld;

    if (s == 0) begin : g_src
      assign i_e   = in_e;
      assign i_nq  = in_nq;
      assign i_vld = vld_in;
    end else begin : g_src
      assign i_e   = g_st[s-1].o_e;
      assign i_nq  = g_st[s-1].o_nq;
      assign i_vld = g_st[s-1].o_vld;
    end

    // Odd element must be strictly larger, so ties keep the lower key.
    always_comb begin
      for (int i = 0; i < NO; i++) begin
        if (i_e[2*i+1].s > i_e[2*i].s) begin
          c_e[i]        = i_e[2*i+1];
          c_e[i].key[s] = 1'b1;
        end else begin
          c_e[i] = i_e[2*i];
        end
      end
    end

    if (PIPE_MASK[s]) begin : g_reg
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < NO; i++) o_e[i] <= '0;
          o_nq  <= '0;
          o_vld <= 1'b0;
        end else begin
          o_e   <= c_e;
          o_nq  <= i_nq;
          o_vld <= i_vld;
        end
      end
    end else begin : g_wire
      assign o_e   = c_e;
      assign o_nq  = i_nq;
      assign o_vld = i_vld;
    end
  end

  elem_t          fin;
  logic [NQW-1:0] fin_nq;
  logic           fin_vld;
  logic           win;
  logic           unused_fin_s;

  assign fin          = g_st[NST-1].o_e[0];
  assign fin_nq       = g_st[NST-1].o_nq;
  assign fin_vld      = g_st[NST-1].o_vld;
  assign win          = fin_vld & fin.q;
  assign unused_fin_s = ^fin.s;

  always_ff @(posedge clock) begin
    if (reset) begin
      best_pat   <= '0;
      best_key   <= '0;
      best_carry <= '0;
      best_vld   <= 1'b0;
      nqual      <= '0;
    end else begin
      best_pat   <= win ? fin.pat   : '0;
      best_key   <= win ? fin.key   : '0;
      best_carry <= win ? fin.carry : '0;
      best_vld   <= win;
      nqual      <= win ? fin_nq    : '0;
    end
  end

endmodule
